// File: rtl/bp_gf16_inv_pipe.sv
// bp_gf16_inv_pipe: LANES x GF(2^4) Boyar-Peralta inverters feeding a STAGES-deep valid/ready pipe.
// Define BP_GF16_INV_PIPE_CHECK_EN to carry the input nibbles and flag results that fail f(f(x))=x.

module bp_gf16_inv (
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);
  logic a, b, c, d;
  logic m24, m25, m26, m27, m28, m29, m30, m31, m32;
  logic m33, m34, m35, m36, m37, m38, m39, m40;

  assign a = i_x[0];
  assign b = i_x[1];
  assign c = i_x[2];
  assign d = i_x[3];

  // Nonlinear core of the Boyar-Peralta S-box, kept gate-for-gate
  assign m24 = c ^ d;
  assign m25 = a & c;
  assign m26 = b ^ m25;
  assign m27 = a ^ b;
  assign m28 = d ^ m25;
  assign m29 = m28 & m27;
  assign m30 = m26 & m24;
  assign m31 = a & d;
  assign m32 = m27 & m31;
  assign m33 = m27 ^ m25;
  assign m34 = b & c;
  assign m35 = m24 & m34;
  assign m36 = m24 ^ m25;
  assign m37 = b ^ m29;
  assign m38 = m32 ^ m33;
  assign m39 = d ^ m30;
  assign m40 = m35 ^ m36;

  // Output bit order is reversed so the result shares the input basis (f is an involution)
  assign o_y = {m37, m38, m39, m40};
endmodule

module bp_gf16_inv_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [4*LANES-1:0] i_x,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [4*LANES-1:0] o_y,
  output logic [LANES-1:0]   o_err
);
  localparam int W = 4 * LANES;

  logic [W-1:0]             inv_y;
  logic [STAGES:1]          vld_pipe_q, vld_pipe_d;
  logic [STAGES:1][W-1:0]   dat_q, dat_d;
  logic [STAGES:1]          rdy;
  logic [STAGES:0]          vin;
  logic [STAGES:0][W-1:0]   din;
  logic [W-1:0]             y_out;

  genvar n;
  generate
    for (n = 0; n < LANES; n++) begin : g_lane
      bp_gf16_inv u_inv (
        .i_x (i_x[4*n +: 4]),
        .o_y (inv_y[4*n +: 4])
      );
    end
  endgenerate

  // Index 0 is the input side, index STAGES is the output register
  assign vin = {vld_pipe_q, i_valid};
  assign din = {dat_q, inv_y};

  // A stage can load if it is empty or everything downstream of it drains this cycle
  always_comb begin
    logic acc;
    acc = i_ready;
    rdy = '0;
    for (int k = STAGES; k >= 1; k--) begin
      acc    = ~vld_pipe_q[k] | acc;
      rdy[k] = acc;
    end
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    dat_d      = dat_q;
    if (i_flush) begin
      vld_pipe_d = '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (rdy[k]) begin
          vld_pipe_d[k] = vin[k-1];
          if (vin[k-1]) dat_d[k] = din[k-1];
        end
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      vld_pipe_q <= '0;
      dat_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_q      <= dat_d;
    end
  end

  assign o_ready = rdy[1] & ~i_flush;
  assign o_valid = vin[STAGES];
  assign y_out   = din[STAGES];
  assign o_y     = y_out;

`ifdef BP_GF16_INV_PIPE_CHECK_EN
  logic [STAGES:1][W-1:0] xin_q, xin_d;
  logic [STAGES:0][W-1:0] xsrc;
  logic [W-1:0]           chk_x;

  assign xsrc = {xin_q, i_x};

  // Original nibbles follow their result through the pipe with the same load enables
  always_comb begin
    xin_d = xin_q;
    if (!i_flush) begin
      for (int k = 1; k <= STAGES; k++) begin
        if (rdy[k] && vin[k-1]) xin_d[k] = xsrc[k-1];
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) xin_q <= '0;
    else           xin_q <= xin_d;
  end

  generate
    for (n = 0; n < LANES; n++) begin : g_chk
      bp_gf16_inv u_chk (
        .i_x (y_out[4*n +: 4]),
        .o_y (chk_x[4*n +: 4])
      );
      assign o_err[n] = o_valid & (chk_x[4*n +: 4] != xsrc[STAGES][4*n +: 4]);
    end
  endgenerate
`else
  assign o_err = '0;
`endif
endmodule
